// File: rtl/bus_out_pkg.sv
// -----------------------------------------------------------------------------
// bus_out_pkg
// Shared constants for the PE bus-output merger:
//   DATA_SIZE_DEF  - default width of one bus part
//   LG()           - ceil(log2(n)), minimum 1, for sizing index fields
//   EXTRA_EN/VAL   - bit positions inside a source's 2-bit extraBitValue field
//   CONFLICT_CNT_W - width of the saturating conflict counter
// -----------------------------------------------------------------------------
package bus_out_pkg;

    localparam int DATA_SIZE_DEF  = 8;

    // Field layout of one {enable, value} extra-bit pair.
    localparam int EXTRA_EN       = 1;
    localparam int EXTRA_VAL      = 0;

    localparam int CONFLICT_CNT_W = 8;

    function automatic int LG(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_out_merge_comb.sv
// -----------------------------------------------------------------------------
// bus_out_merge_comb
// Purely combinational priority merge of NUM_SRC bus claims.
//   instOut        in  per-source data, source s at [s*BUS_W +: BUS_W]
//   validPart      in  per-source part-claim bitmap, source s at [s*NUM_PARTS +: NUM_PARTS]
//   extraBitToSet  in  per-source extra-bit index, source s at [s*IDX_W +: IDX_W]
//   extraBitValue  in  per-source {enable, value}, source s at [s*2 +: 2]
//   mergedData     out merged word, unclaimed bits 0
//   mergedMask     out 1 = bit driven by a part claim or an extra bit
//   claim          out at least one part claim or one enabled in-range extra bit
//   conflict       out a part claimed twice, or two extra bits on one index
// Priority: higher source index wins for parts; extra bits override part data
// and are applied in ascending source order, so the highest index wins there too.
// -----------------------------------------------------------------------------
module bus_out_merge_comb
    import bus_out_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int NUM_PARTS = 2,
    parameter int NUM_SRC   = 2,
    parameter int IDX_W     = LG(DATA_SIZE * NUM_PARTS) + 1
) (
    input  logic [NUM_SRC*DATA_SIZE*NUM_PARTS-1:0] instOut,
    input  logic [NUM_SRC*NUM_PARTS-1:0]           validPart,
    input  logic [NUM_SRC*IDX_W-1:0]               extraBitToSet,
    input  logic [NUM_SRC*2-1:0]                   extraBitValue,
    output logic [DATA_SIZE*NUM_PARTS-1:0]         mergedData,
    output logic [DATA_SIZE*NUM_PARTS-1:0]         mergedMask,
    output logic                                   claim,
    output logic                                   conflict
);

    localparam int BUS_W = DATA_SIZE * NUM_PARTS;

    logic [BUS_W-1:0]     partData;
    logic [BUS_W-1:0]     partMask;
    logic [NUM_PARTS-1:0] partClaimed;
    logic [NUM_PARTS-1:0] partMulti;
    logic [BUS_W-1:0]     extHit;
    logic [BUS_W-1:0]     extMulti;

    genvar gi;

    // Per-part selection: ascending scan, so the last (highest) claimant sticks.
    generate
        for (gi = 0; gi < NUM_PARTS; gi++) begin : gPart
            logic [DATA_SIZE-1:0] selData;
            logic                 anyClaim;
            logic                 multiClaim;

            always_comb begin
                selData    = '0;
                anyClaim   = 1'b0;
                multiClaim = 1'b0;
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (validPart[s*NUM_PARTS + gi]) begin
                        if (anyClaim) begin
                            multiClaim = 1'b1;
                        end
                        anyClaim = 1'b1;
                        selData  = instOut[s*BUS_W + gi*DATA_SIZE +: DATA_SIZE];
                    end
                end
            end

            assign partData[gi*DATA_SIZE +: DATA_SIZE] = selData;
            assign partMask[gi*DATA_SIZE +: DATA_SIZE] = {DATA_SIZE{anyClaim}};
            assign partClaimed[gi]                     = anyClaim;
            assign partMulti[gi]                       = multiClaim;
        end
    endgenerate

    // Per-bit extra override. Matching against the bit position itself means
    // indices >= BUS_W can never hit, so they drop out of claim and conflict.
    generate
        for (gi = 0; gi < BUS_W; gi++) begin : gBit
            logic hit;
            logic val;
            logic multi;

            always_comb begin
                hit   = 1'b0;
                val   = 1'b0;
                multi = 1'b0;
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (extraBitValue[s*2 + EXTRA_EN] &&
                        (extraBitToSet[s*IDX_W +: IDX_W] == IDX_W'(gi))) begin
                        if (hit) begin
                            multi = 1'b1;
                        end
                        hit = 1'b1;
                        val = extraBitValue[s*2 + EXTRA_VAL];
                    end
                end
            end

            assign extHit[gi]     = hit;
            assign extMulti[gi]   = multi;
            assign mergedData[gi] = hit ? val : partData[gi];
            assign mergedMask[gi] = hit | partMask[gi];
        end
    endgenerate

    assign claim    = (|partClaimed) | (|extHit);
    assign conflict = (|partMulti) | (|extMulti);

endmodule

// File: rtl/bus_out_merger.sv
// -----------------------------------------------------------------------------
// bus_out_merger
// Registered bus-output merger: priority-merges NUM_SRC claims into a one-entry
// output stage with a valid/ready handshake toward the interconnect.
//   clk            in  rising-edge clock
//   reset          in  asynchronous active-high reset
//   instOut        in  per-source data, source s at [s*BUS_W +: BUS_W]
//   validPart      in  per-source part-claim bitmap
//   extraBitToSet  in  per-source extra-bit index (>= BUS_W ignored)
//   extraBitValue  in  per-source {enable, value}
//   inReady        out stage can accept a claim this cycle
//   outValid       out stage holds a merged word
//   outReady       in  downstream consumes outData this cycle
//   outData        out merged word
//   outMask        out bits driven by some claim
//   conflictFlag   out sticky overlap indicator
//   conflictCount  out saturating overlap count
//   conflictClr    in  synchronous clear of flag and count
// Build option: define BUS_OUT_CONFLICT_CNT_EN to enable conflict tracking;
// otherwise conflictFlag/conflictCount are 0 and conflictClr is ignored.
// -----------------------------------------------------------------------------
module bus_out_merger
    import bus_out_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int NUM_PARTS = 2,
    parameter int NUM_SRC   = 2,
    parameter int IDX_W     = LG(DATA_SIZE * NUM_PARTS) + 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_SRC*DATA_SIZE*NUM_PARTS-1:0] instOut,
    input  logic [NUM_SRC*NUM_PARTS-1:0]           validPart,
    input  logic [NUM_SRC*IDX_W-1:0]               extraBitToSet,
    input  logic [NUM_SRC*2-1:0]                   extraBitValue,
    output logic                                   inReady,
    output logic                                   outValid,
    input  logic                                   outReady,
    output logic [DATA_SIZE*NUM_PARTS-1:0]         outData,
    output logic [DATA_SIZE*NUM_PARTS-1:0]         outMask,
    output logic                                   conflictFlag,
    output logic [CONFLICT_CNT_W-1:0]              conflictCount,
    input  logic                                   conflictClr
);

    localparam int BUS_W = DATA_SIZE * NUM_PARTS;

    logic [BUS_W-1:0] mergedData;
    logic [BUS_W-1:0] mergedMask;
    logic             mergeClaim;
    logic             mergeConflict;

    logic             outValidReg;
    logic [BUS_W-1:0] outDataReg;
    logic [BUS_W-1:0] outMaskReg;

    bus_out_merge_comb #(
        .DATA_SIZE (DATA_SIZE),
        .NUM_PARTS (NUM_PARTS),
        .NUM_SRC   (NUM_SRC),
        .IDX_W     (IDX_W)
    ) uMerge (
        .instOut       (instOut),
        .validPart     (validPart),
        .extraBitToSet (extraBitToSet),
        .extraBitValue (extraBitValue),
        .mergedData    (mergedData),
        .mergedMask    (mergedMask),
        .claim         (mergeClaim),
        .conflict      (mergeConflict)
    );

    // Stage is free when empty or being drained this cycle, which gives
    // full throughput with no bubble on a simultaneous consume-and-load.
    assign inReady = !outValidReg || outReady;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValidReg <= 1'b0;
            outDataReg  <= '0;
            outMaskReg  <= '0;
        end else if (inReady) begin
            if (mergeClaim) begin
                outValidReg <= 1'b1;
                outDataReg  <= mergedData;
                outMaskReg  <= mergedMask;
            end else begin
                outValidReg <= 1'b0;
            end
        end
    end

    assign outValid = outValidReg;
    assign outData  = outDataReg;
    assign outMask  = outMaskReg;

`ifdef BUS_OUT_CONFLICT_CNT_EN
    logic                      conflictFlagReg;
    logic [CONFLICT_CNT_W-1:0] conflictCountReg;
    logic                      captureConflict;

    // Only cycles that actually load the stage are counted.
    assign captureConflict = inReady && mergeClaim && mergeConflict;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflictFlagReg  <= 1'b0;
            conflictCountReg <= '0;
        end else if (conflictClr) begin
            // A conflict coinciding with the clear survives as the first event.
            conflictFlagReg  <= captureConflict;
            conflictCountReg <= captureConflict ? CONFLICT_CNT_W'(1) : '0;
        end else if (captureConflict) begin
            conflictFlagReg <= 1'b1;
            if (conflictCountReg != '1) begin
                conflictCountReg <= conflictCountReg + CONFLICT_CNT_W'(1);
            end
        end
    end

    assign conflictFlag  = conflictFlagReg;
    assign conflictCount = conflictCountReg;
`else
    logic unusedConflict;

    assign unusedConflict = conflictClr | mergeConflict;
    assign conflictFlag   = 1'b0;
    assign conflictCount  = '0;
`endif

endmodule

// File: doc/bus_out_merger.md
# bus_out_merger

Registered, parametrised bus-output merger for a PE. Up to NUM_SRC instruction slots each claim parts of a NUM_PARTS×DATA_SIZE output bus, and may also force one extra bit. Claims are merged by fixed priority and captured into a one-entry output stage with a valid/ready handshake toward the interconnect. Overlapping claims are detected and counted.

## Interface
- DATA_SIZE, 8, width of one bus part
- NUM_PARTS, 2, parts per bus word; BUS_W = DATA_SIZE*NUM_PARTS
- NUM_SRC, 2, number of claiming slots; higher index has higher priority
- IDX_W, $clog2(BUS_W)+1, width of extra-bit index; indices ≥ BUS_W are ignored
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- instOut  in  NUM_SRC*BUS_W  per-source data, source s at [s*BUS_W +: BUS_W]
- validPart  in  NUM_SRC*NUM_PARTS  per-source part-claim bitmap; bit p claims bits [p*DATA_SIZE +: DATA_SIZE]
- extraBitToSet  in  NUM_SRC*IDX_W  per-source extra-bit index
- extraBitValue  in  NUM_SRC*2  per-source {enable, value}
- inReady  out  1  merger accepts claims this cycle
- outValid  out  1  output stage holds a merged word
- outReady  in  1  downstream consumes outData this cycle
- outData  out  BUS_W  merged word; unclaimed bits are 0
- outMask  out  BUS_W  1 = bit driven by some claim
- conflictFlag  out  1  sticky overlap indicator (macro-gated)
- conflictCount  out  8  saturating overlap count (macro-gated)
- conflictClr  in  1  synchronous clear of the flag and the counter (macro-gated)

## Operation
- inReady = !outValid || outReady. This is combinational and has no dependency on claim inputs.
- Claim present = any validPart bit set, or any extraBitValue[1] set with an in-range index.
- Merge, in order:
  - Part p takes data from the highest-index source claiming p, and its mask bits are set.
  - Extra bits are applied next, in ascending source order, so the highest index wins. An extra bit overrides part data at that position and sets its mask bit.
- Capture: when inReady && claim present, outData/outMask/outValid load the merge result next edge.
- Release: when inReady && no claim, outValid clears. When outValid && !outReady, the stage holds and all inputs are ignored.
- Conflict: a part claimed by ≥2 sources, or ≥2 enabled in-range extra bits targeting the same index, in a captured cycle. An extra bit overriding a part claim is not a conflict.
- Each conflicting captured cycle sets conflictFlag and adds 1 to conflictCount, which saturates at 255.

## Timing
- Reset values: outValid=0, outData=0, outMask=0, conflictFlag=0, conflictCount=0. inReady=1 while in reset.
- Latency: one cycle from the capture edge to outValid/outData.
- Throughput: one word per cycle while outReady stays high.
- Simultaneous outReady and capture: the old word is consumed and the new word is loaded on the same edge, with no bubble.
- conflictClr together with a conflicting capture: result is flag=1, count=1, so the event is not lost.
- Reset asserted mid-transfer: the held word is dropped and outValid=0 immediately (asynchronous).
- Out-of-range index (≥ BUS_W): that extra bit is ignored and does not count toward conflicts.

## Configuration
- BUS_OUT_CONFLICT_CNT_EN defined: conflict detection, conflictFlag, conflictCount and conflictClr are present.
- BUS_OUT_CONFLICT_CNT_EN undefined: detection logic is removed. conflictFlag and conflictCount are tied to 0, conflictClr is ignored, and merge behaviour is identical.

## Structure
- Package bus_out_pkg holds:
  - DATA_SIZE default and LG helper
  - extra-bit field positions (EXTRA_EN=1, EXTRA_VAL=0)
  - CONFLICT_CNT_W=8
- Sub-module bus_out_merge_comb: purely combinational priority merge plus conflict detect. It produces mergedData, mergedMask, claim and conflict. The top level holds the handshake, the registers and the counter.

## Test plan
- Reset, then src0 validPart=2'b11, data 0xA55A → one cycle later outValid=1, outData=0xA55A, outMask=0xFFFF.
- src0 part1 data 0x12xx, src1 part0 data 0xxx34 → outData=0x1234, outMask=0xFFFF, conflictCount=0.
- Both sources claim part0 (src0 0x11, src1 0x22) → outData[7:0]=0x22, conflictFlag=1, conflictCount=1. 300 such cycles → count=255.
- outReady=0 with outValid=1, new claim 0xBEEF → inReady=0 and outData is held. Raise outReady → next edge outData=0xBEEF.
- src1 extraBitValue=2'b11, index 15, plus src0 part0 0x7F → outData=0x807F, outMask=0x80FF. Index 16 → ignored, outMask=0x00FF.
- conflictClr in the same cycle as a conflicting capture → flag=1, count=1. Built without the macro → flag and count stay 0.
